byte_bus_master: RTL and testbench
==================================

# byte_bus_master

Initiator for the byte-wide RAM port. It takes one CPU load or store request (byte, halfword or word, little-endian) and performs it as a sequence of single-byte accesses on the RAM's output_enable/read_data/address/write_data/write_enable/illegal_address interface. Loads are assembled and sign- or zero-extended to 32 bits. Misaligned accesses, unsupported widths and illegal addresses are reported as a fault. It sits between the CPU execute stage and ram_memory.

## Interface
- ADDR_W, 32, address width on both CPU and memory sides.
- clk  input  1  rising-edge clock; the only clock.
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
- start  input  1  request strobe; accepted only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- width  input  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- is_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- address  input  ADDR_W  byte address of the access.
- store_data  input  32  store data; the low 8, 16 or 32 bits are used.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle completion pulse.
- fault  output  1  valid with done; high on misalignment, illegal width or illegal address.
- load_data  output  32  extended load result; held until the next accepted start.
- mem_address  output  ADDR_W  RAM byte address.
- mem_write_data  output  8  RAM write byte.
- mem_write_enable  output  1  RAM write strobe; the RAM writes on rising clk.
- mem_output_enable  output  1  RAM read enable.
- mem_read_data  input  8  RAM read byte, combinational from mem_address.
- mem_illegal_address  input  1  RAM out-of-range flag, combinational from mem_address.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE with start=1: latch is_store, width, is_unsigned, address and store_data. Set N = 1, 2 or 4. Clear the byte index k and the load assembly register.
  - If width=11, or a halfword address has address[0]=1, or a word address has address[1:0]≠0: go to DONE with fault=1. No memory access is made.
  - Otherwise go to ACCESS.
- ACCESS, byte k:
  - mem_address = latched address + k. The add wraps modulo 2^ADDR_W.
  - Store: mem_write_data = store_data[8k+7:8k] and mem_write_enable = !mem_illegal_address. mem_output_enable=0.
  - Load: mem_output_enable=1 and mem_write_enable=0. Capture mem_read_data into assembly bits [8k+7:8k] at the clock edge.
  - If mem_illegal_address=1: go to DONE with fault=1. Bytes already stored stay written. load_data is forced to 0.
  - Else if k=N-1: go to DONE.
  - Else k <= k+1.
- DONE: done=1 for one cycle. For a fault-free load, load_data is updated with the result. The block returns to IDLE. A start in this cycle is ignored.
- Extension rules:
  - Byte load: bits [31:8] are copied from bit 7 (sign-extend) or set to 0 (is_unsigned=1).
  - Halfword load: bits [31:16] are copied from bit 15 or set to 0.
  - Word load: no extension.
- fault holds its value until the next accepted start. Stores leave load_data unchanged.
- In IDLE and DONE, all mem_* outputs are 0.
- start while busy=1 is ignored. There is no queueing.

## Timing
- Reset (reset_n=0 at a rising edge): state IDLE. busy, done, fault, load_data, mem_address, mem_write_data, mem_write_enable and mem_output_enable are all 0.
- Reset mid-ACCESS takes effect at that edge. No further byte is written. Bytes already written are not undone.
- start is accepted at edge T. Byte k is driven during cycle T+1+k. done is high during cycle T+1+N.
- Cycle count by width:
  - Byte: 1 byte access, so start-to-done is 2 cycles.
  - Halfword: 2 byte accesses, so start-to-done is 3 cycles.
  - Word: 4 byte accesses, so start-to-done is 5 cycles.
- Misaligned or illegal-width request: done+fault in cycle T+1.
- Illegal address at byte k: done+fault in cycle T+2+k.
- busy is high during cycles T+1 through T+N. It is low in the DONE cycle.
- Back-to-back requests: the next start is accepted at the earliest in the cycle after DONE. The minimum period is N+2 cycles.
- mem_* outputs are decoded from registered state only. They have no combinational path from start or address.
- mem_write_enable is gated combinationally by mem_illegal_address within the same cycle.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load from 0x10. Required response:
  - Store bytes EF, BE, AD, DE are written at 0x10 to 0x13 in cycles T+1 to T+4.
  - The load returns load_data=0xDEADBEEF with done at T+5 and fault=0.
- Byte 0x80 at address 0x21:
  - Signed byte load returns 0xFFFFFF80.
  - Unsigned byte load returns 0x00000080.
  - Signed halfword 0x8001 at 0x20 returns 0xFFFF8001.
- Misalignment and width faults:
  - Halfword store at 0x03 gives done+fault at T+1 with mem_write_enable never high.
  - Word load at 0x02 gives fault with load_data=0.
  - width=11 gives fault.
- Out-of-range access with the RAM default depth (8192 bytes):
  - Word store at 0x2000 gives done+fault at T+2 and no RAM write.
  - Byte load at 0x1FFF succeeds.
- Reset and start handling:
  - reset_n=0 in cycle T+2 of a word store: only bytes 0 and 1 are written, and all outputs are 0 the next cycle.
  - start pulses while busy and during DONE are ignored.
- Back-to-back: byte store then byte load, with start held high continuously. Required response: two completions 3 cycles apart, and the load returns the stored byte.

Source files
------------

// File: rtl/byte_bus_master.sv
// Byte-wide RAM initiator: runs one CPU load/store (byte/half/word, little-endian)
// as a sequence of single-byte RAM accesses, with sign/zero extension and fault reporting.
module byte_bus_master #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              is_store,
   input  logic [1:0]        width,
   input  logic              is_unsigned,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       store_data,
   output logic              busy,
   output logic              done,
   output logic              fault,
   output logic [31:0]       load_data,
   output logic [ADDR_W-1:0] mem_address,
   output logic [7:0]        mem_write_data,
   output logic              mem_write_enable,
   output logic              mem_output_enable,
   input  logic [7:0]        mem_read_data,
   input  logic              mem_illegal_address
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   typedef struct packed {
      logic              is_store;
      logic [1:0]        width;
      logic              is_unsigned;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } req_t;

   state_t      state, state_nxt;
   req_t        req;
   logic [1:0]  k;
   logic [1:0]  last_k;
   logic [31:0] asm_q;
   logic [31:0] asm_full;
   logic [31:0] ext;
   logic        misaligned;
   logic        fault_q;
   logic [31:0] load_q;

   assign misaligned = (width == 2'b11) ||
                       (width == 2'b01 && address[0]) ||
                       (width == 2'b10 && address[1:0] != 2'b00);

   always_comb begin
      case (req.width)
         2'b00:   last_k = 2'd0;
         2'b01:   last_k = 2'd1;
         default: last_k = 2'd3;
      endcase
   end

   // Assembly including the byte arriving this cycle, so the result is ready on the DONE entry edge
   always_comb begin
      asm_full = asm_q;
      asm_full[{k, 3'b000} +: 8] = mem_read_data;
      case (req.width)
         2'b00:   ext = {{24{~req.is_unsigned & asm_full[7]}},  asm_full[7:0]};
         2'b01:   ext = {{16{~req.is_unsigned & asm_full[15]}}, asm_full[15:0]};
         default: ext = asm_full;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = misaligned ? DONE : ACCESS;
         ACCESS:  if (mem_illegal_address || k == last_k) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // RAM-side signals come only from registered state
   always_comb begin
      mem_address       = '0;
      mem_write_data    = '0;
      mem_write_enable  = 1'b0;
      mem_output_enable = 1'b0;
      if (state == ACCESS) begin
         mem_address = req.addr + ADDR_W'(k);
         if (req.is_store) begin
            mem_write_data   = req.wdata[{k, 3'b000} +: 8];
            mem_write_enable = ~mem_illegal_address;
         end else begin
            mem_output_enable = 1'b1;
         end
      end
   end

   assign busy      = (state == ACCESS);
   assign done      = (state == DONE);
   assign fault     = fault_q;
   assign load_data = load_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         req     <= '0;
         k       <= '0;
         asm_q   <= '0;
         fault_q <= 1'b0;
         load_q  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (start) begin
               req     <= '{is_store: is_store, width: width, is_unsigned: is_unsigned,
                            addr: address, wdata: store_data};
               k       <= '0;
               asm_q   <= '0;
               fault_q <= misaligned;
               if (misaligned) load_q <= '0;
            end
            ACCESS: begin
               if (mem_illegal_address) begin
                  fault_q <= 1'b1;
                  load_q  <= '0;
               end else begin
                  if (!req.is_store) asm_q <= asm_full;
                  if (k == last_k) begin
                     if (!req.is_store) load_q <= ext;
                  end else begin
                     k <= k + 2'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_byte_bus_master.sv
// Randomized bench for byte_bus_master against a transaction-level model of an 8 KiB byte RAM.
module tb_byte_bus_master;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        is_store;
   logic [1:0]  width;
   logic        is_unsigned;
   logic [31:0] address;
   logic [31:0] store_data;
   logic        busy, done, fault;
   logic [31:0] load_data;
   logic [31:0] mem_address;
   logic [7:0]  mem_write_data;
   logic        mem_write_enable, mem_output_enable;
   logic [7:0]  mem_read_data;
   logic        mem_illegal_address;

   int checks = 0;
   int errors = 0;

   logic [7:0]  ram    [0:8191];
   logic [7:0]  shadow [0:8191];
   bit          preload;
   int          wr_total;
   logic [31:0] ld_exp;
   bit          ld_known;

   byte_bus_master #(.ADDR_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .is_store(is_store), .width(width),
      .is_unsigned(is_unsigned), .address(address), .store_data(store_data),
      .busy(busy), .done(done), .fault(fault), .load_data(load_data),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write_enable(mem_write_enable), .mem_output_enable(mem_output_enable),
      .mem_read_data(mem_read_data), .mem_illegal_address(mem_illegal_address)
   );

   always #5 clk = ~clk;

   assign mem_illegal_address = (mem_address >= 32'd8192);
   assign mem_read_data = mem_illegal_address ? 8'h00 : ram[mem_address[12:0]];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 8192; i++) ram[i] <= shadow[i];
         wr_total <= 0;
      end else if (mem_write_enable) begin
         ram[mem_address[12:0]] <= mem_write_data;
         wr_total <= wr_total + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Expected outcome of one request; updates the shadow RAM for stores
   task automatic model(input bit st, input logic [1:0] w, input bit uns, input logic [31:0] a,
                        input logic [31:0] sd, output int lat, output bit flt,
                        output logic [31:0] ld, output int nwr);
      int n, good;
      longint v;
      logic [31:0] ai;
      n   = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
      ld  = '0;
      nwr = 0;
      if (w == 2'd3 || (a % 32'(n)) != 0) begin
         lat = 1;
         flt = 1'b1;
         return;
      end
      good = 0;
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         if (ai >= 32'd8192) break;
         good++;
      end
      flt = (good < n);
      lat = flt ? good + 2 : n + 1;
      if (st) begin
         nwr = good;
         for (int i = 0; i < good; i++) begin
            ai = a + 32'(i);
            shadow[ai[12:0]] = 8'(sd >> (8 * i));
         end
      end else if (!flt) begin
         v = 0;
         for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            v += longint'(shadow[ai[12:0]]) << (8 * i);
         end
         if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
         ld = 32'(v);
      end
   endtask

   task automatic run_txn(input bit st, input logic [1:0] w, input bit uns, input logic [31:0] a,
                          input logic [31:0] sd, input bit spam);
      int lat, nwr, c, wr0;
      bit flt;
      logic [31:0] ld, ai;
      model(st, w, uns, a, sd, lat, flt, ld, nwr);
      wr0 = wr_total;
      is_store = st; width = w; is_unsigned = uns; address = a; store_data = sd; start = 1'b1;
      @(posedge clk); #1;
      start = spam;
      c = 1;
      while (!done && c < 12) begin
         chk("busy", busy, 1);
         chk("oe", mem_output_enable, !st);
         chk("mem_addr", mem_address, a + 32'(c - 1));
         if (st) chk("wdata", mem_write_data, (sd >> (8 * (c - 1))) & 32'hff);
         if (spam) begin
            address = $urandom; store_data = $urandom;
            width = 2'($urandom); is_store = 1'($urandom);
         end
         @(posedge clk); #1;
         c++;
      end
      chk("latency", c, lat);
      chk("fault", fault, flt);
      chk("busy_done", busy, 0);
      chk("done_we", mem_write_enable, 0);
      chk("done_oe", mem_output_enable, 0);
      chk("done_addr", mem_address, 0);
      chk("writes", wr_total - wr0, nwr);
      if (!st) chk("load_data", load_data, flt ? 32'h0 : ld);
      else if (!flt && ld_known) chk("ld_hold", load_data, ld_exp);
      if (!st) begin
         ld_exp = flt ? 32'h0 : ld;
         ld_known = 1'b1;
      end else if (flt) begin
         ld_known = 1'b0;
      end
      if (st) for (int j = 0; j < 4; j++) begin
         ai = a + 32'(j);
         if (ai < 32'd8192) chk("ram", ram[ai[12:0]], shadow[ai[12:0]]);
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("fault_hold", fault, flt);
      if (ld_known) chk("ld_held", load_data, ld_exp);
   endtask

   initial begin
      int c, t1, t2;
      bit got1;
      logic [31:0] a;
      logic [1:0]  w;
      reset_n = 1'b0; start = 1'b0; is_store = 1'b0; width = 2'd0; is_unsigned = 1'b0;
      address = '0; store_data = '0;
      for (int i = 0; i < 8192; i++) shadow[i] = 8'($urandom);
      preload = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      preload = 1'b0;
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_fault", fault, 0);
      chk("rst_ld", load_data, 0); chk("rst_addr", mem_address, 0);
      chk("rst_wdata", mem_write_data, 0); chk("rst_we", mem_write_enable, 0);
      chk("rst_oe", mem_output_enable, 0);
      reset_n = 1'b1;
      ld_exp = 32'h0; ld_known = 1'b1;
      @(posedge clk); #1;

      run_txn(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
      run_txn(0, 2'd2, 0, 32'h10, 32'h0, 0);
      chk("word_rt", load_data, 32'hDEADBEEF);
      run_txn(1, 2'd0, 0, 32'h21, 32'h12345680, 0);
      run_txn(0, 2'd0, 0, 32'h21, 32'h0, 0);
      chk("sbyte", load_data, 32'hFFFFFF80);
      run_txn(0, 2'd0, 1, 32'h21, 32'h0, 0);
      chk("ubyte", load_data, 32'h00000080);
      run_txn(1, 2'd0, 0, 32'h20, 32'h01, 0);
      run_txn(0, 2'd1, 0, 32'h20, 32'h0, 0);
      chk("shalf", load_data, 32'hFFFF8001);
      run_txn(1, 2'd1, 0, 32'h03, 32'hCAFE, 0);
      run_txn(0, 2'd2, 0, 32'h02, 32'h0, 0);
      run_txn(0, 2'd3, 0, 32'h40, 32'h0, 0);
      run_txn(1, 2'd2, 0, 32'h2000, 32'h55667788, 0);
      run_txn(0, 2'd0, 1, 32'h1FFF, 32'h0, 0);
      run_txn(0, 2'd2, 0, 32'hFFFFFFFC, 32'h0, 0);
      run_txn(1, 2'd2, 0, 32'h30, 32'hA1B2C3D4, 1);

      // reset in the third cycle of a word store: bytes 0 and 1 land, 2 and 3 do not
      is_store = 1'b1; width = 2'd2; address = 32'h40; store_data = 32'h11223344; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_busy", busy, 0); chk("mid_done", done, 0); chk("mid_fault", fault, 0);
      chk("mid_ld", load_data, 0); chk("mid_addr", mem_address, 0);
      chk("mid_we", mem_write_enable, 0); chk("mid_oe", mem_output_enable, 0);
      chk("mid_wdata", mem_write_data, 0);
      reset_n = 1'b1;
      shadow[12'h40] = 8'h44;
      shadow[12'h41] = 8'h33;
      for (int j = 'h40; j < 'h44; j++) chk("mid_ram", ram[j], shadow[j]);
      ld_exp = 32'h0; ld_known = 1'b1;
      @(posedge clk); #1;

      // back-to-back with start held high
      is_store = 1'b1; width = 2'd0; is_unsigned = 1'b0; address = 32'h55; store_data = 32'hA5;
      start = 1'b1;
      @(posedge clk); #1;
      is_store = 1'b0;
      c = 1; got1 = 1'b0; t1 = 0; t2 = 0;
      while (c < 20) begin
         if (done) begin
            if (!got1) begin t1 = c; got1 = 1'b1; end
            else begin t2 = c; break; end
         end
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0;
      chk("b2b_first", t1, 2);
      chk("b2b_gap", t2 - t1, 3);
      chk("b2b_load", load_data, 32'hFFFFFFA5);
      shadow[12'h55] = 8'hA5;
      ld_exp = 32'hFFFFFFA5; ld_known = 1'b1;
      @(posedge clk); #1;

      for (int n = 0; n < 150; n++) begin
         w = 2'($urandom_range(3, 0));
         case ($urandom_range(3, 0))
            0:       a = 32'($urandom_range(63, 0));
            1:       a = 32'($urandom_range(8191, 0));
            2:       a = 32'h2000 - 32'($urandom_range(8, 0));
            default: a = $urandom;
         endcase
         if ($urandom_range(3, 0) != 0) a = (w == 2'd1) ? {a[31:1], 1'b0} : (w == 2'd2) ? {a[31:2], 2'b00} : a;
         run_txn(1'($urandom), w, 1'($urandom), a, $urandom, $urandom_range(3, 0) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
